// File: rtl/alu_seq_if.sv
// alu_seq_if: operation/result handshake bundle for alu_seq.
//   master: producer/consumer side (drives operands, op, in_valid, out_ready, clr_sticky)
//   slave : the ALU (drives in_ready, out_valid, result, flags, sticky_ovf, busy)
interface alu_seq_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   op;
  logic         clr_sticky;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         sign;
  logic         overflow;
  logic         status;
  logic         sticky_ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, op, clr_sticky, out_ready,
    input  in_ready, out_valid, result, sign, overflow, status, sticky_ovf, busy
  );

  modport slave (
    input  in_valid, a, b, op, clr_sticky, out_ready,
    output in_ready, out_valid, result, sign, overflow, status, sticky_ovf, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle signed ALU with valid/ready handshake on both sides.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_seq_if.slave (operands/op in, result/flags out, sticky overflow)
// Single-cycle ops finish on the first BUSY edge; square runs one multiplier bit
// per cycle (N cycles); shift does one arithmetic step per cycle.
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready=1
// BUSY  | computing, counter holds remaining steps
// DONE  | result/flags held until out_ready
module alu_seq #(
  parameter int N   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_seq_if.slave bus
);
  localparam int          CW   = $clog2(N + 1);
  localparam logic [31:0] NU   = N;
  localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MAX = 3'b010, OP_LE  = 3'b011,
                         OP_AVG = 3'b100, OP_SQR = 3'b101, OP_ABS = 3'b110, OP_SHR = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d, mc_q, mc_d;
  logic [N-1:0]   res_q, res_d;
  logic           sign_q, sign_d, ovf_q, ovf_d, stat_q, stat_d, sticky_q, sticky_d;

  logic [N-1:0]   sum, dif, avg, abs_in, shr_nx, r_new;
  logic [N:0]     avg_sum;
  logic [2*N-1:0] prod_nx;
  logic           add_ovf, sub_ovf, sq_ovf, le, last, s_new, o_new, st_new;

  // Datapath for the final BUSY cycle
  always_comb begin
    sum     = a_q + b_q;
    dif     = a_q - b_q;
    add_ovf = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
    sub_ovf = (a_q[N-1] != b_q[N-1]) && (dif[N-1] != a_q[N-1]);
    avg_sum = {a_q[N-1], a_q} + {b_q[N-1], b_q};
    avg     = avg_sum[N:1];
    le      = $signed(a_q) <= $signed(b_q);
    abs_in  = bus.a[N-1] ? -bus.a : bus.a;
    // For square a_q holds |a| as an unsigned multiplier shifting right
    prod_nx = acc_q + (a_q[0] ? mc_q : '0);
    sq_ovf  = prod_nx > {{(N+1){1'b0}}, {(N-1){1'b1}}};
    // cnt_q==0 only for a zero shift amount: pass a through unchanged
    shr_nx  = (cnt_q != '0) ? N'($signed(a_q) >>> 1) : a_q;
    last    = (cnt_q <= CW'(1));

    r_new  = '0;
    s_new  = 1'b0;
    o_new  = 1'b0;
    st_new = 1'b0;
    case (op_q)
      OP_ADD: begin
        o_new = add_ovf;
        r_new = (SAT && add_ovf) ? (a_q[N-1] ? SMIN : SMAX) : sum;
        s_new = r_new[N-1];
      end
      OP_SUB: begin
        o_new = sub_ovf;
        r_new = (SAT && sub_ovf) ? (a_q[N-1] ? SMIN : SMAX) : dif;
        s_new = r_new[N-1];
      end
      OP_MAX: begin
        r_new = ($signed(a_q) > $signed(b_q)) ? a_q : b_q;
        s_new = r_new[N-1];
      end
      OP_LE: begin
        r_new  = {{(N-1){1'b0}}, le};
        st_new = le;
      end
      OP_AVG: r_new = avg;
      OP_SQR: begin
        r_new = prod_nx[N-1:0];
        o_new = sq_ovf;
        s_new = r_new[N-1];
      end
      OP_ABS: begin
        r_new = a_q[N-1] ? -a_q : a_q;
        o_new = (a_q == SMIN);
      end
      default: begin
        r_new = shr_nx;
        s_new = r_new[N-1];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    res_d    = res_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    stat_d   = stat_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d   = (bus.op == OP_SQR) ? abs_in : bus.a;
          b_d   = bus.b;
          op_d  = bus.op;
          acc_d = '0;
          mc_d  = {{N{1'b0}}, abs_in};
          case (bus.op)
            OP_SQR:  cnt_d = CW'(N);
            OP_SHR:  cnt_d = (32'(bus.b) >= NU) ? CW'(N) : CW'(bus.b);
            default: cnt_d = CW'(1);
          endcase
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (op_q == OP_SQR) begin
          acc_d = prod_nx;
          a_d   = a_q >> 1;
          mc_d  = mc_q << 1;
        end else if (op_q == OP_SHR) begin
          a_d = shr_nx;
        end
        if (last) begin
          state_d = DONE;
          res_d   = r_new;
          sign_d  = s_new;
          ovf_d   = o_new;
          stat_d  = st_new;
          if (o_new) sticky_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.clr_sticky) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      res_q    <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      stat_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      res_q    <= res_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      stat_q   <= stat_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q == BUSY);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.result     = res_q;
  assign bus.sign       = sign_q;
  assign bus.overflow   = ovf_q;
  assign bus.status     = stat_q;
  assign bus.sticky_ovf = sticky_q;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  bit         sel = 1'b0;   // 0: SAT=0 instance observed, 1: SAT=1 instance

  alu_seq_if #(.N(N)) if0 ();
  alu_seq_if #(.N(N)) if1 ();

  alu_seq #(.N(N), .SAT(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  alu_seq #(.N(N), .SAT(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.in_valid = in_valid;   assign if1.in_valid = in_valid;
  assign if0.a = a;                 assign if1.a = a;
  assign if0.b = b;                 assign if1.b = b;
  assign if0.op = op;               assign if1.op = op;
  assign if0.clr_sticky = clr;      assign if1.clr_sticky = clr;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  logic       o_in_ready, o_out_valid, o_sign, o_ovf, o_stat, o_sticky, o_busy;
  logic [7:0] o_result;
  assign o_in_ready  = sel ? if1.in_ready   : if0.in_ready;
  assign o_out_valid = sel ? if1.out_valid  : if0.out_valid;
  assign o_result    = sel ? if1.result     : if0.result;
  assign o_sign      = sel ? if1.sign       : if0.sign;
  assign o_ovf       = sel ? if1.overflow   : if0.overflow;
  assign o_stat      = sel ? if1.status     : if0.status;
  assign o_sticky    = sel ? if1.sticky_ovf : if0.sticky_ovf;
  assign o_busy      = sel ? if1.busy       : if0.busy;

  int   checks = 0;
  int   failures = 0;
  logic sticky_m = 1'b0;
  logic [7:0] last_res;
  logic last_ovf, last_sign, last_stat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed operand values
  function automatic void model(input logic [2:0] o, input logic [7:0] ai, input logic [7:0] bi,
                                input bit sat, output logic [7:0] r, output logic s,
                                output logic ov, output logic st, output int c);
    int sa, sb, t;
    sa = int'($signed(ai));
    sb = int'($signed(bi));
    r = '0; s = 1'b0; ov = 1'b0; st = 1'b0; c = 1;
    case (o)
      3'd0, 3'd1: begin
        t  = (o == 3'd0) ? sa + sb : sa - sb;
        ov = (t > 127) || (t < -128);
        if (sat && ov) t = (t > 0) ? 127 : -128;
        r = 8'(t); s = r[7];
      end
      3'd2: begin t = (sa > sb) ? sa : sb; r = 8'(t); s = r[7]; end
      3'd3: begin st = (sa <= sb); r = {7'd0, st}; end
      3'd4: begin t = (sa + sb) >>> 1; r = 8'(t); end
      3'd5: begin t = sa * sa; ov = (t > 127); r = 8'(t); s = r[7]; c = 8; end
      3'd6: begin t = (sa < 0) ? -sa : sa; r = 8'(t); ov = (sa == -128); end
      default: begin
        t = int'(bi);
        r = (t >= 8) ? ((sa < 0) ? 8'hFF : 8'h00) : 8'(sa >>> t);
        s = r[7];
        c = (t == 0) ? 1 : ((t > 8) ? 8 : t);
      end
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input int hold, input bit clr_done);
    logic [7:0] er;
    logic es, eo, est;
    int ec, lat;
    model(o, av, bv, sel, er, es, eo, est, ec);
    @(negedge clk);
    chk("in_ready_idle", o_in_ready, 1);
    in_valid = 1'b1; op = o; a = av; b = bv; out_ready = 1'b0; clr = clr_done;
    @(negedge clk);
    chk("busy_after_accept", o_busy, 1);
    a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
    lat = 0;
    while (!o_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      a = 8'($urandom); b = 8'($urandom);
    end
    chk("latency", lat, ec);
    if (clr_done) sticky_m = 1'b0;
    else if (eo) sticky_m = 1'b1;
    clr = 1'b0;
    chk("result", o_result, er);
    chk("sign", o_sign, es);
    chk("overflow", o_ovf, eo);
    chk("status", o_stat, est);
    chk("sticky", o_sticky, sticky_m);
    chk("in_ready_done", o_in_ready, 0);
    last_res = o_result; last_ovf = o_ovf; last_sign = o_sign; last_stat = o_stat;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      chk("hold_result", o_result, er);
      chk("hold_ovf", o_ovf, eo);
      chk("hold_valid", o_out_valid, 1);
      chk("hold_in_ready", o_in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", o_out_valid, 0);
    chk("release_ready", o_in_ready, 1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_result", o_result, 0);
    chk("rst_sticky", o_sticky, 0);
    rst_n = 1'b1;

    // SAT=0 directed cases
    do_op(3'd0, 8'd100, 8'd50, 0, 1'b0);
    chk("add_res", last_res, 8'h96); chk("add_ovf", last_ovf, 1); chk("add_sign", last_sign, 1);
    do_op(3'd5, 8'hF4, 8'h00, 0, 1'b0);
    chk("sq_neg_res", last_res, 8'h90); chk("sq_neg_ovf", last_ovf, 1);
    do_op(3'd5, 8'd11, 8'h00, 0, 1'b0);
    chk("sq_pos_res", last_res, 8'h79); chk("sq_pos_ovf", last_ovf, 0);
    do_op(3'd7, 8'h80, 8'd3, 0, 1'b0);
    chk("shr3_res", last_res, 8'hF0); chk("shr3_sign", last_sign, 1);
    do_op(3'd7, 8'h80, 8'd200, 0, 1'b0);
    chk("shr200_res", last_res, 8'hFF);
    do_op(3'd7, 8'h5A, 8'd0, 0, 1'b0);
    do_op(3'd6, 8'h80, 8'h00, 0, 1'b0);
    // Backpressure plus clear on the same edge as an overflowing result
    do_op(3'd0, 8'd100, 8'd50, 5, 1'b1);
    chk("clr_priority", o_sticky, 0);

    for (int i = 0; i < 40; i++)
      do_op(3'($urandom), 8'($urandom), 8'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 1'b0);

    // SAT=1 instance
    sel = 1'b1;
    do_op(3'd0, 8'd100, 8'd50, 0, 1'b0);
    chk("sat_add_res", last_res, 8'h7F); chk("sat_add_ovf", last_ovf, 1);
    do_op(3'd1, 8'h9C, 8'd50, 0, 1'b0);
    chk("sat_sub_res", last_res, 8'h80); chk("sat_sub_ovf", last_ovf, 1);
    for (int i = 0; i < 40; i++)
      do_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);

    // Reset in the middle of a square
    sel = 1'b0;
    do_op(3'd0, 8'd100, 8'd50, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; op = 3'd5; a = 8'hF4; b = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_valid", o_out_valid, 0);
    chk("mid_rst_result", o_result, 0);
    chk("mid_rst_flags", {o_sign, o_ovf, o_stat}, 0);
    chk("mid_rst_sticky", o_sticky, 0);
    sticky_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_ready", o_in_ready, 1);
    begin
      logic seen;
      seen = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (o_out_valid) seen = 1'b1;
      end
      chk("abandoned_op_silent", seen, 0);
    end
    do_op(3'd3, 8'hFD, 8'd2, 0, 1'b0);
    chk("le_res", last_res, 8'h01); chk("le_status", last_stat, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
